// File: rtl/line_buffer_feeder_stride_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_feeder_stride_1_pkg
//  Description : Shared definitions for the line-buffer feeder. Holds the
//                feeder FSM state encoding and the default frame geometry.
//                The line-buffer control block uses the same frame size.
//  Revision    : 1.0 - initial release
// ============================================================================
package line_buffer_feeder_stride_1_pkg;

    // Default frame geometry. y is the inner scan dimension.
    localparam int DEF_INPUT_Y  = 3;
    localparam int DEF_INPUT_X  = 3;
    localparam int FRAME_PIXELS = DEF_INPUT_X * DEF_INPUT_Y;

    // Feeder FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LAST  = 3'd2,
        ST_ARM   = 3'd3,
        ST_DRAIN = 3'd4
    } feeder_state_t;

endpackage : line_buffer_feeder_stride_1_pkg
`default_nettype wire

// File: rtl/line_buffer_feeder_stride_1_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_scan_counter
//  Description : Column-major scan counters for one feature-map frame.
//                y counts 0..input_y-1 (inner), x counts 0..input_x-1
//                (outer); the address counter simply increments, which
//                equals base + x*input_y + y and wraps modulo 2**ADDR_WIDTH.
//  Ports       : clk, rst       - clock, async active-high reset
//                load/base_addr - restart scan at base_addr (priority)
//                en             - advance one pixel
//                addr           - current read address
//                first/last     - current pixel is first / last of frame
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_scan_counter
    import line_buffer_feeder_stride_1_pkg::*;
#(
    parameter int input_y    = DEF_INPUT_Y,
    parameter int input_x    = DEF_INPUT_X,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  first,
    output logic                  last
);

    localparam int YW = (input_y > 1) ? $clog2(input_y) : 1;
    localparam int XW = (input_x > 1) ? $clog2(input_x) : 1;
    localparam logic [YW-1:0] Y_LAST = YW'(input_y - 1);
    localparam logic [XW-1:0] X_LAST = XW'(input_x - 1);

    logic [YW-1:0]         y_q, y_d;
    logic [XW-1:0]         x_q, x_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        y_d    = y_q;
        x_d    = x_q;
        addr_d = addr_q;
        if (load) begin
            y_d    = '0;
            x_d    = '0;
            addr_d = base_addr;
        end else if (en) begin
            addr_d = addr_q + 1'b1;
            if (y_q == Y_LAST) begin
                y_d = '0;
                x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            x_q    <= '0;
            addr_q <= '0;
        end else begin
            y_q    <= y_d;
            x_q    <= x_d;
            addr_q <= addr_d;
        end
    end

    assign addr  = addr_q;
    assign first = (y_q == '0) && (x_q == '0);
    assign last  = (y_q == Y_LAST) && (x_q == X_LAST);

endmodule : line_buffer_scan_counter
`default_nettype wire

// File: rtl/line_buffer_feeder_stride_1.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_feeder_stride_1
//  Description : Streams one input_y x input_x feature map from on-chip
//                memory into the 3x3 line buffer, one pixel per cycle, with
//                sof/input_valid. A new frame starts only once the line
//                buffer control has finished flushing (lb_busy low).
//  Ports       : clk, rst            - clock, async active-high reset
//                start, base_addr    - frame request and start address
//                hold                - suppress this cycle's read
//                lb_busy             - line-buffer flush in progress
//                mem_rd_en/mem_addr  - memory read request
//                mem_rd_data         - read data, one cycle after mem_rd_en
//                pixel_out/input_valid/sof - pixel stream to line buffer
//                active/done         - frame in progress / frame flushed
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_feeder_stride_1
    import line_buffer_feeder_stride_1_pkg::*;
#(
    parameter int input_y    = DEF_INPUT_Y,
    parameter int input_x    = DEF_INPUT_X,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  hold,
    input  logic                  lb_busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  input_valid,
    output logic                  sof,
    output logic                  active,
    output logic                  done
);

    feeder_state_t state_q, state_d;
    logic          pending_q, pending_d;
    logic          input_valid_q, input_valid_d;
    logic          sof_q, sof_d;
    logic          done_q, done_d;

    logic          rd_en;
    logic          cnt_load;
    logic          cnt_en;
    logic          scan_first;
    logic          scan_last;

    line_buffer_scan_counter #(
        .input_y    (input_y),
        .input_x    (input_x),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .base_addr (base_addr),
        .en        (cnt_en),
        .addr      (mem_addr),
        .first     (scan_first),
        .last      (scan_last)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        rd_en     = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The address is captured with the start pulse itself, so a
                // start parked behind lb_busy keeps its own base address.
                cnt_load = start;
                if ((start || pending_q) && !lb_busy) begin
                    pending_d = 1'b0;
                    state_d   = ST_ISSUE;
                end else if (start) begin
                    pending_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    rd_en  = 1'b1;
                    cnt_en = 1'b1;
                    if (scan_last) begin
                        state_d = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                state_d = ST_ARM;
            end
            // lb_busy is registered from the last input_valid downstream;
            // this cycle gives it time to rise before DRAIN samples it.
            ST_ARM: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!lb_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        input_valid_d = rd_en;
        sof_d         = rd_en && scan_first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            input_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            input_valid_q <= input_valid_d;
            sof_q         <= sof_d;
            done_q        <= done_d;
        end
    end

    // The memory's read register is the pipeline stage for the data; it
    // lines up with input_valid_q, and is gated so idle/reset outputs are 0.
    assign mem_rd_en   = rd_en;
    assign input_valid = input_valid_q;
    assign pixel_out   = input_valid_q ? mem_rd_data : '0;
    assign sof         = sof_q;
    assign active      = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule : line_buffer_feeder_stride_1
`default_nettype wire
